// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle between the register-station slicer and the register bank.
// Latency: none; the bundle carries only wires.
// Backpressure: valid/ready on AW, W, B, AR and R; master drives requests, slave drives responses.
//
// Signals: awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready,
//          bresp/bvalid/bready, araddr/arprot/arvalid/arready,
//          rdata/rresp/rvalid/rready.
interface axil_reg_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite completer terminating reads/writes in NUM_REGS byte-strobed registers.
// Latency: write commits and raises B one edge after both AW and W are held; R valid from the AR edge.
// Backpressure: AW/W stall while a B is pending or the channel is held; AR stalls while R is pending.
//
// Ports: aclk, aresetn (async active-low), s_axi (slave modport of axil_reg_bank_if),
//        regs_o (reg i at [i*DATA_WIDTH +: DATA_WIDTH]), wr_pulse_o (one-cycle commit strobe per reg).
// Optional: define AXIL_REG_BANK_PROT_CHECK_EN to answer unprivileged accesses (prot[0]=0) with SLVERR.
module axil_reg_bank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axil_reg_bank_if.slave                 s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);
  // Bank span in bytes, one bit wider than the address so the compare cannot wrap.
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * STRB_WIDTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef AXIL_REG_BANK_PROT_CHECK_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [2:0]            aw_prot_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Handshakes; readies depend on registered state only
  // ---------------------------------------------------------------------------
  logic aw_fire;
  logic w_fire;
  logic ar_fire;
  logic commit;

  assign s_axi.awready = ~aw_held & ~bvalid_q;
  assign s_axi.wready  = ~w_held  & ~bvalid_q;
  assign s_axi.arready = ~rvalid_q;

  assign aw_fire = s_axi.awvalid & s_axi.awready;
  assign w_fire  = s_axi.wvalid  & s_axi.wready;
  assign ar_fire = s_axi.arvalid & s_axi.arready;
  // Both halves of the write are in hand; this cycle's edge performs the commit.
  assign commit  = aw_held & w_held;

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rdata  = rdata_q;
  assign wr_pulse_o   = wr_pulse_q;

  // ---------------------------------------------------------------------------
  // Write decode, on the latched address
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_off;
  logic                  wr_decerr;
  logic [IDX_W-1:0]      wr_idx;
  logic [1:0]            wr_resp;

  assign wr_off    = aw_addr_q - BASE_ADDR;
  assign wr_decerr = (aw_addr_q < BASE_ADDR) || ({1'b0, wr_off} >= SPAN);
  assign wr_idx    = wr_off[ADDR_LSB +: IDX_W];

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_decerr) begin
      wr_resp = RESP_DECERR;
    end
`ifdef AXIL_REG_BANK_PROT_CHECK_EN
    else if (!aw_prot_q[0]) begin
      wr_resp = RESP_SLVERR;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Read decode, straight off the AR channel
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_off;
  logic                  rd_decerr;
  logic [IDX_W-1:0]      rd_idx;
  logic [1:0]            rd_resp;

  assign rd_off    = s_axi.araddr - BASE_ADDR;
  assign rd_decerr = (s_axi.araddr < BASE_ADDR) || ({1'b0, rd_off} >= SPAN);
  assign rd_idx    = rd_off[ADDR_LSB +: IDX_W];

  always_comb begin
    rd_resp = RESP_OKAY;
    if (rd_decerr) begin
      rd_resp = RESP_DECERR;
    end
`ifdef AXIL_REG_BANK_PROT_CHECK_EN
    else if (!s_axi.arprot[0]) begin
      rd_resp = RESP_SLVERR;
    end
`endif
  end

  // Prot bits not consumed by the decode above.
  logic unused_ok;
  assign unused_ok = ^{aw_prot_q, s_axi.arprot};

  // ---------------------------------------------------------------------------
  // Write path: capture AW and W independently, commit, answer on B
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held    <= 1'b0;
      aw_addr_q  <= '0;
      aw_prot_q  <= '0;
      w_held     <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        // Readies are low while both flags are held, so no capture can collide here.
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (wr_resp == RESP_OKAY) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_q[b]) begin
              regs_q[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
          // An all-zero strobe is an accepted no-op and must not look like an update.
          wr_pulse_q[wr_idx] <= |w_strb_q;
        end
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi.awaddr;
          aw_prot_q <= s_axi.awprot;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
        if (bvalid_q && s_axi.bready) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: sample the bank on the AR edge, hold R until accepted.
  // Sampling uses the pre-edge register value, so a commit on the same edge
  // to the same register returns the old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= (rd_resp == RESP_OKAY) ? regs_q[rd_idx] : '0;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flat register view for the fabric
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Randomized self-checking bench for axil_reg_bank against an array model of the bank.
// Latency: checks B one edge after the last of AW/W, R on the AR edge.
// Backpressure: exercises held bready/rready and staggered AW/W arrival.
module tb_axil_reg_bank;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_pulse_o;

  axil_reg_bank #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .BASE_ADDR (32'h0)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_axi     (s_axi),
    .regs_o    (regs_o),
    .wr_pulse_o(wr_pulse_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain array of register words.
  logic [DW-1:0] model [NR];

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr, input logic [2:0] prot);
    if (addr >= NR * (DW / 8)) return 2'b11;
`ifdef AXIL_REG_BANK_PROT_CHECK_EN
    if (!prot[0]) return 2'b10;
`endif
    if (prot == 3'b111) return 2'b00;  // any prot is fine otherwise
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                      input logic [3:0] strb);
    logic [DW-1:0] mask;
    int idx;
    idx  = int'(addr) / 4;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    model[idx] = (model[idx] & ~mask) | (data & mask);
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int aw_dly, input int w_dly, input int b_dly);
    logic aw_done, w_done, aw_fire, w_fire;
    logic [1:0] er;
    logic [NR-1:0] ep;
    int cyc;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    er = exp_resp(addr, prot);
    s_axi.awaddr = addr; s_axi.awprot = prot;
    s_axi.wdata = data;  s_axi.wstrb = strb;
    while (!(aw_done && w_done)) begin
      s_axi.awvalid = !aw_done && (cyc >= aw_dly);
      s_axi.wvalid  = !w_done && (cyc >= w_dly);
      @(negedge aclk);
      aw_fire = s_axi.awvalid && s_axi.awready;
      w_fire  = s_axi.wvalid && s_axi.wready;
      @(posedge aclk); #1;
      if (aw_fire) aw_done = 1'b1;
      if (w_fire) w_done = 1'b1;
      cyc++;
      if (cyc > 60) begin
        check("wr_handshake_timeout", 1, 0);
        break;
      end
    end
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("b_early", s_axi.bvalid, 0);
    @(posedge aclk); #1;
    if (er == 2'b00) model_write(addr, data, strb);
    ep = (er == 2'b00 && strb != 4'h0) ? (16'h1 << (int'(addr) / 4)) : 16'h0;
    check("bvalid", s_axi.bvalid, 1);
    check("bresp", s_axi.bresp, er);
    check("wr_pulse", wr_pulse_o, ep);
    check("regs_after_commit", regs_o, model_flat());
    for (int i = 0; i < b_dly; i++) begin
      @(posedge aclk); #1;
      check("b_hold_valid", s_axi.bvalid, 1);
      check("b_hold_resp", s_axi.bresp, er);
      check("b_hold_awready", s_axi.awready, 0);
      check("b_hold_wready", s_axi.wready, 0);
      check("b_hold_pulse", wr_pulse_o, 0);
    end
    s_axi.bready = 1'b1;
    @(posedge aclk); #1;
    s_axi.bready = 1'b0;
    check("b_cleared", s_axi.bvalid, 0);
    check("pulse_one_cycle", wr_pulse_o, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [2:0] prot, input int r_dly);
    logic [1:0] er;
    logic [DW-1:0] ed;
    logic fire;
    int cyc;
    er = exp_resp(addr, prot);
    ed = (er == 2'b00) ? model[int'(addr) / 4] : '0;
    s_axi.araddr = addr; s_axi.arprot = prot; s_axi.arvalid = 1'b1;
    cyc = 0; fire = 1'b0;
    while (!fire) begin
      @(negedge aclk);
      fire = s_axi.arvalid && s_axi.arready;
      @(posedge aclk); #1;
      cyc++;
      if (!fire && cyc > 60) begin
        check("rd_handshake_timeout", 1, 0);
        break;
      end
    end
    s_axi.arvalid = 1'b0;
    check("rvalid", s_axi.rvalid, 1);
    check("rdata", s_axi.rdata, ed);
    check("rresp", s_axi.rresp, er);
    for (int i = 0; i < r_dly; i++) begin
      @(posedge aclk); #1;
      check("r_hold_valid", s_axi.rvalid, 1);
      check("r_hold_data", s_axi.rdata, ed);
      check("r_hold_arready", s_axi.arready, 0);
    end
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0;
    check("r_cleared", s_axi.rvalid, 0);
    check("arready_back", s_axi.arready, 1);
  endtask

  initial begin
    logic [DW-1:0] old;
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;  s_axi.wstrb = '0;  s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", s_axi.awready, 1);
    check("rst_wready", s_axi.wready, 1);
    check("rst_arready", s_axi.arready, 1);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_regs", regs_o, 0);
    check("rst_pulse", wr_pulse_o, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Directed: same-cycle AW+W
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0);
    check("t1_reg1", regs_o[63:32], 32'hDEADBEEF);
    // W first, AW three cycles later, single lane
    do_write(32'h4, 32'h000000AA, 4'h1, 3'b001, 3, 0, 0);
    check("t2_reg1", regs_o[63:32], 32'hDEADBEAA);
    // AW first, W later
    do_write(32'h3C, 32'hCAFEF00D, 4'hC, 3'b001, 0, 2, 1);
    // Out of range
    do_write(32'h40, 32'h11111111, 4'hF, 3'b001, 0, 0, 0);
    do_read(32'h40, 3'b001, 0);
    // Zero strobe: OKAY, no change, no pulse
    do_write(32'h8, 32'h55555555, 4'h0, 3'b001, 0, 0, 0);
    // Long B stall
    do_write(32'h8, 32'h0BADCAFE, 4'hF, 3'b001, 0, 0, 5);
    do_read(32'h8, 3'b001, 2);
    do_read(32'h6, 3'b001, 0);

    // Read on the same edge as a commit to the same register returns the old value
    old = model[1];
    s_axi.awaddr = 32'h4; s_axi.awprot = 3'b001; s_axi.wdata = 32'h12345678; s_axi.wstrb = 4'hF;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("coll_b_early", s_axi.bvalid, 0);
    s_axi.araddr = 32'h4; s_axi.arprot = 3'b001; s_axi.arvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    model_write(32'h4, 32'h12345678, 4'hF);
    check("coll_rvalid", s_axi.rvalid, 1);
    check("coll_rdata_old", s_axi.rdata, old);
    check("coll_bvalid", s_axi.bvalid, 1);
    check("coll_regs", regs_o, model_flat());
    s_axi.rready = 1'b1; s_axi.bready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0; s_axi.bready = 1'b0;
    check("coll_r_clear", s_axi.rvalid, 0);
    check("coll_b_clear", s_axi.bvalid, 0);
    do_read(32'h4, 3'b001, 0);
    check("coll_new_value", s_axi.rdata, 32'h12345678);

`ifdef AXIL_REG_BANK_PROT_CHECK_EN
    do_write(32'hC, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 0, 0);
    do_write(32'hC, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0, 0);
    do_read(32'hC, 3'b000, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 32'h47));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, 3'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a write discards the captured AW
    s_axi.awaddr = 32'h10; s_axi.awprot = 3'b001; s_axi.awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0;
    check("mid_aw_held", s_axi.awready, 0);
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("mid_rst_awready", s_axi.awready, 1);
    check("mid_rst_regs", regs_o, model_flat());
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    s_axi.wdata = 32'h77777777; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check("mid_no_bvalid", s_axi.bvalid, 0);
      check("mid_w_held", s_axi.wready, 0);
    end
    check("mid_regs_unchanged", regs_o, model_flat());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
